apb_master: RTL and testbench

APB requester (initiator) that turns a simple valid/ready command port into single APB3 transfers toward the LPDDR controller's register file and other APB completers on the same bus. It drives setup/access phases, honours `pready` wait states, captures read data and `pslverr`, and aborts stalled transfers after a programmable timeout. It sits between the test/config sequencer logic and the APB slave side of `lpddr_ctl`.

---
 rtl/apb_master.sv | 88 ++++++++
 tb/tb_apb_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: valid/ready command port to single APB3 transfers with wait states and timeout abort
`ifndef APB_DEPTH
`define APB_DEPTH 8
`endif
`ifndef APB_WIDTH
`define APB_WIDTH 32
`endif
module apb_master #(
  parameter int ADDR_W  = `APB_DEPTH,
  parameter int DATA_W  = `APB_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  assign cmd_ready = state == IDLE;
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state       <= IDLE;
      cnt         <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          paddr  <= cmd_addr;
          pwdata <= cmd_wdata;
          pwrite <= cmd_write;
          psel   <= 1'b1;
          cnt    <= '0;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: if (pready) begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err   <= pslverr;
        end else if (TIMEOUT != 0 && cnt == TMAX) begin
          psel        <= 1'b0;
          penable     <= 1'b0;
          state       <= IDLE;
          rsp_valid   <= 1'b1;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scenario tasks with a response scoreboard against a programmable APB completer model
module tb_apb_master;
  localparam int AW = 8, DW = 32, TO = 16;
  logic pclk = 0, preset = 1;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, paddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic rsp_valid, rsp_err, rsp_timeout, pwrite, psel, penable, pready, pslverr;
  typedef struct packed {logic [DW-1:0] rdata; logic err; logic to;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, waits = 0;
  logic [DW-1:0] comp_rdata = '0;
  logic comp_err = 0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr));

  always #5 pclk = ~pclk;

  // completer: ready after `waits` stalled ACCESS cycles, garbage data/error while stalled
  assign pready  = psel && penable && acc_cnt >= waits;
  assign prdata  = pready ? comp_rdata : 32'hDEAD_BEEF;
  assign pslverr = pready ? comp_err : 1'b1;

  always @(posedge pclk) begin
    cyc     <= cyc + 1;
    acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
  end

  always @(negedge pclk)
    if (!preset && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout} !== mon_e) begin
          errors++;
          $display("FAIL rsp_fields: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                   rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.to);
        end
      end
    end

  task automatic test_reset;
    #3;
    checks++;
    if (cmd_ready !== 1 || psel !== 0 || penable !== 0 || pwrite !== 0 || paddr !== 0 ||
        pwdata !== 0 || rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || rsp_timeout !== 0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rsp=%b/%h/%b/%b, required 1 and all zero",
               cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    repeat (2) @(negedge pclk);
    #2 preset = 0;
  endtask

  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int nw, input logic [DW-1:0] rd, input logic er, input logic to);
    int t0, exp_c;
    logic done;
    waits = nw;
    comp_rdata = rd;
    comp_err = er;
    exp_q.push_back({(w || to) ? '0 : rd, er | to, to});
    @(negedge pclk);
    checks++;
    if (cmd_ready !== 1) begin
      errors++;
      $display("FAIL idle_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge pclk); #1;
    cmd_valid = 0;
    t0 = cyc;
    exp_c = t0 + 2 + (to ? TO : nw);
    @(negedge pclk);
    checks++;
    if (!(psel === 1 && penable === 0 && paddr === a && pwrite === w && pwdata === d && cmd_ready === 0)) begin
      errors++;
      $display("FAIL setup_phase: got psel=%b pen=%b paddr=%h pwr=%b pwdata=%h ready=%b, required 1 0 %h %b %h 0",
               psel, penable, paddr, pwrite, pwdata, cmd_ready, a, w, d);
    end
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge pclk);
      if (rsp_valid) done = 1;
      else begin
        checks++;
        if (!(psel === 1 && penable === 1 && paddr === a && pwrite === w && pwdata === d && cmd_ready === 0)) begin
          errors++;
          $display("FAIL access_phase: cycle %0d got psel=%b pen=%b paddr=%h pwr=%b pwdata=%h ready=%b, required 1 1 %h %b %h 0",
                   cyc - t0, psel, penable, paddr, pwrite, pwdata, cmd_ready, a, w, d);
        end
      end
    end
    checks++;
    if (!done || cyc != exp_c || psel !== 0 || penable !== 0 || cmd_ready !== 1) begin
      errors++;
      $display("FAIL rsp_timing: got done=%b latency=%0d psel=%b pen=%b ready=%b, required 1 %0d 0 0 1",
               done, cyc - t0, psel, penable, cmd_ready, exp_c - t0);
    end
    @(negedge pclk);
    checks++;
    if (rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || rsp_timeout !== 0) begin
      errors++;
      $display("FAIL rsp_clear: got %b/%h/%b/%b, required all zero", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
  endtask

  task automatic test_back_to_back;
    int hs[$];
    waits = 0;
    comp_err = 0;
    repeat (3) exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(posedge pclk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10; cmd_wdata = 32'h1234_5678;
    for (int i = 0; i < 40 && hs.size() < 3; i++) begin
      @(negedge pclk);
      if (cmd_ready) hs.push_back(cyc);
    end
    @(posedge pclk); #1;
    cmd_valid = 0;
    repeat (5) @(negedge pclk);
    checks++;
    if (hs.size() != 3 || hs[1] - hs[0] != 3 || hs[2] - hs[1] != 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d handshakes spacing %0d/%0d, required 3 handshakes spacing 3/3",
               hs.size(), hs.size() > 1 ? hs[1] - hs[0] : 0, hs.size() > 2 ? hs[2] - hs[1] : 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_responses: got %0d missing responses, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    waits = 1000;
    @(posedge pclk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20; cmd_wdata = '0;
    @(posedge pclk); #1;
    cmd_valid = 0;
    repeat (3) @(negedge pclk);
    checks++;
    if (psel !== 1 || penable !== 1) begin
      errors++;
      $display("FAIL pre_reset_access: got psel=%b pen=%b, required 1 1", psel, penable);
    end
    #2 preset = 1;
    #1;
    checks++;
    if (psel !== 0 || penable !== 0 || cmd_ready !== 1 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL reset_async: got psel=%b pen=%b ready=%b rsp=%b, required 0 0 1 0", psel, penable, cmd_ready, rsp_valid);
    end
    @(negedge pclk);
    #2 preset = 0;
    repeat (4) @(negedge pclk);
    checks++;
    if (psel !== 0 || cmd_ready !== 1 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL reset_release: got psel=%b ready=%b rsp=%b, required 0 1 0", psel, cmd_ready, rsp_valid);
    end
    run_cmd(0, 8'h21, '0, 0, 32'h0BAD_CAFE, 0, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    test_reset;
    run_cmd(1, 8'h03, 32'hA5A5_A5A5, 0, 32'h0, 0, 0);
    run_cmd(0, 8'h03, 32'h0, 0, 32'hA5A5_A5A5, 0, 0);
    run_cmd(0, 8'h07, 32'h0, 4, 32'h1357_9BDF, 0, 0);
    run_cmd(0, 8'h08, 32'h0, 1000, 32'hFFFF_FFFF, 0, 1);
    run_cmd(1, 8'h09, 32'h5555_AAAA, 0, 32'h0, 1, 0);
    run_cmd(0, 8'h0A, 32'h0, TO, 32'hC0DE_0016, 1, 0);
    run_cmd(1, 8'hFF, 32'hFFFF_FFFF, 2, 32'h0, 0, 0);
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
